brnch_tag_alloc: RTL and testbench

//  Allocates, tracks and retires the in-flight branch slots whose count limits fetch.

---
 rtl/brnch_tag_alloc_if.sv | 40 ++++
 rtl/brnch_tag_alloc.sv | 108 ++++++++++
 tb/tb_brnch_tag_alloc.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brnch_tag_alloc_if.sv
// Bundle between the fetch-stage branch handler / ROB (master) and the branch tag allocator (slave).
// Valid/ready semantics: alloc_req[i] is a request valid and alloc_gnt[i] is its same-cycle ready;
// a slot is taken only on a cycle where both are high. commit_vld is valid-only (the allocator never back-pressures it).
interface brnch_tag_alloc_if #(
    parameter int TAG_W = 1
);
    logic [1:0]       alloc_req;
    logic [15:0]      alloc_pc0;
    logic [15:0]      alloc_pc1;
    logic [15:0]      alloc_tgt0;
    logic [15:0]      alloc_tgt1;
    logic [1:0]       alloc_pred;
    logic [1:0]       alloc_gnt;
    logic [TAG_W-1:0] alloc_tag0;
    logic [TAG_W-1:0] alloc_tag1;
    logic             commit_vld;
    logic [TAG_W-1:0] commit_tag;
    logic             commit_mispred;
    logic [TAG_W:0]   brnch_cnt;
    logic             brch_full;
    logic             redirect_vld;
    logic [15:0]      redirect_pc;
    logic             stall_fetch;
    logic             err_tag;
    logic             dbg_state;

    modport master (
        output alloc_req, alloc_pc0, alloc_pc1, alloc_tgt0, alloc_tgt1, alloc_pred,
        output commit_vld, commit_tag, commit_mispred,
        input  alloc_gnt, alloc_tag0, alloc_tag1, brnch_cnt, brch_full,
        input  redirect_vld, redirect_pc, stall_fetch, err_tag, dbg_state
    );

    modport slave (
        input  alloc_req, alloc_pc0, alloc_pc1, alloc_tgt0, alloc_tgt1, alloc_pred,
        input  commit_vld, commit_tag, commit_mispred,
        output alloc_gnt, alloc_tag0, alloc_tag1, brnch_cnt, brch_full,
        output redirect_vld, redirect_pc, stall_fetch, err_tag, dbg_state
    );
endinterface

// File: rtl/brnch_tag_alloc.sv
// In-order branch tag allocator: circular slot FIFO, retire on commit, and a
// flush/redirect/stall recovery sequence on a committed mispredict.
module brnch_tag_alloc #(
    parameter int NUM_TAGS    = 2,
    parameter int TAG_W       = 1,
    parameter int RECOVER_CYC = 3
) (
    input logic               clk,
    input logic               rst_n,
    brnch_tag_alloc_if.slave  bus
);
    localparam int CNT_W = TAG_W + 1;
    localparam int RC_W  = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(NUM_TAGS);
    localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RECOVER_CYC - 1);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    logic [15:0]         pc_q   [NUM_TAGS];
    logic [15:0]         tgt_q  [NUM_TAGS];
    logic [NUM_TAGS-1:0] pred_q;

    logic [TAG_W-1:0] head, tail, tag1;
    logic [CNT_W-1:0] cnt, free, n_alloc;
    logic [0:0]       state;
    logic [RC_W-1:0]  rcnt;
    logic             stall_q, redirect_vld_q, err_q;
    logic [15:0]      redirect_pc_q;
    logic             legal, flush, retire, gate, gnt0, gnt1;

    // Grants look only at the registered count; a commit this cycle frees its slot next cycle.
    always_comb begin
        free    = FULL_C - cnt;
        legal   = bus.commit_vld && (cnt != '0) && (bus.commit_tag == head);
        flush   = legal && bus.commit_mispred;
        retire  = legal && !bus.commit_mispred;
        gate    = (state != ST_IDLE) || flush;
        gnt0    = bus.alloc_req[0] && (free >= CNT_W'(1)) && !gate;
        gnt1    = bus.alloc_req[1] && !gate &&
                  (bus.alloc_req[0] ? (gnt0 && (free >= CNT_W'(2))) : (free >= CNT_W'(1)));
        tag1    = gnt0 ? tail + TAG_W'(1) : tail;
        n_alloc = CNT_W'(gnt0) + CNT_W'(gnt1);
    end

    assign bus.alloc_gnt    = {gnt1, gnt0};
    assign bus.alloc_tag0   = tail;
    assign bus.alloc_tag1   = tag1;
    assign bus.brnch_cnt    = cnt;
    assign bus.brch_full    = (cnt == FULL_C);
    assign bus.redirect_vld = redirect_vld_q;
    assign bus.redirect_pc  = redirect_pc_q;
    assign bus.stall_fetch  = stall_q;
    assign bus.err_tag      = err_q;
    assign bus.dbg_state    = state;

    // Slot payload needs no reset: a slot is only read after it has been granted and written.
    always_ff @(posedge clk) begin
        if (gnt0) begin
            pc_q[tail]   <= bus.alloc_pc0;
            tgt_q[tail]  <= bus.alloc_tgt0;
            pred_q[tail] <= bus.alloc_pred[0];
        end
        if (gnt1) begin
            pc_q[tag1]   <= bus.alloc_pc1;
            tgt_q[tag1]  <= bus.alloc_tgt1;
            pred_q[tag1] <= bus.alloc_pred[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            head           <= '0;
            tail           <= '0;
            state          <= ST_IDLE;
            rcnt           <= '0;
            stall_q        <= 1'b0;
            redirect_vld_q <= 1'b0;
            redirect_pc_q  <= '0;
            err_q          <= 1'b0;
        end else begin
            err_q          <= bus.commit_vld && !legal;
            redirect_vld_q <= flush;
            if (flush) begin
                cnt           <= '0;
                head          <= '0;
                tail          <= '0;
                state         <= ST_RECOVER;
                rcnt          <= RC_LOAD;
                stall_q       <= 1'b1;
                // A taken prediction was wrong, so the fall-through path is correct, and vice versa.
                redirect_pc_q <= pred_q[head] ? pc_q[head] + 16'd1 : tgt_q[head];
            end else begin
                cnt  <= cnt + n_alloc - CNT_W'(retire);
                tail <= tail + TAG_W'(n_alloc);
                if (retire) head <= head + TAG_W'(1);
                if (state == ST_RECOVER) begin
                    if (rcnt == '0) begin
                        state   <= ST_IDLE;
                        stall_q <= 1'b0;
                    end else begin
                        rcnt <= rcnt - RC_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_brnch_tag_alloc.sv
// Directed and random checks of tag grant, retire, mispredict recovery and illegal-commit detection.
module tb_brnch_tag_alloc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_pass = 0;
    int n_total = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    brnch_tag_alloc_if #(.TAG_W(1)) bus();

    brnch_tag_alloc #(.NUM_TAGS(2), .TAG_W(1), .RECOVER_CYC(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.alloc_req      = 2'b00;
        bus.alloc_pc0      = 16'h0;
        bus.alloc_pc1      = 16'h0;
        bus.alloc_tgt0     = 16'h0;
        bus.alloc_tgt1     = 16'h0;
        bus.alloc_pred     = 2'b00;
        bus.commit_vld     = 1'b0;
        bus.commit_tag     = 1'b0;
        bus.commit_mispred = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: redirect targets are queued when the mispredict commit is driven.
    always @(negedge clk) begin
        if (rst_n && bus.redirect_vld === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_redirect_unexpected got=%h exp=none", bus.redirect_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.redirect_pc !== mon_exp)
                    $display("FAIL sb_redirect_pc got=%h exp=%h", bus.redirect_pc, mon_exp);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_total++; if (bus.brnch_cnt !== 2'd0) $display("FAIL rst_cnt got=%0d exp=0", bus.brnch_cnt); else n_pass++;
        n_total++; if (bus.stall_fetch !== 1'b0) $display("FAIL rst_stall got=%b exp=0", bus.stall_fetch); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_total++; if (bus.brnch_cnt !== 2'd0) $display("FAIL rst_cnt_rel got=%0d exp=0", bus.brnch_cnt); else n_pass++;
        n_total++; if (bus.brch_full !== 1'b0) $display("FAIL rst_full got=%b exp=0", bus.brch_full); else n_pass++;
        n_total++; if (bus.redirect_vld !== 1'b0) $display("FAIL rst_rvld got=%b exp=0", bus.redirect_vld); else n_pass++;
        n_total++; if (bus.redirect_pc !== 16'h0) $display("FAIL rst_rpc got=%h exp=0000", bus.redirect_pc); else n_pass++;
        n_total++; if (bus.err_tag !== 1'b0) $display("FAIL rst_err got=%b exp=0", bus.err_tag); else n_pass++;
        n_total++; if (bus.alloc_gnt !== 2'b00) $display("FAIL rst_gnt got=%b exp=00", bus.alloc_gnt); else n_pass++;
        n_total++; if (bus.dbg_state !== 1'b0) $display("FAIL rst_state got=%b exp=0", bus.dbg_state); else n_pass++;
    endtask

    task automatic test_alloc_pair();
        bus.alloc_req = 2'b11; bus.alloc_pc0 = 16'h0010; bus.alloc_pc1 = 16'h0014;
        bus.alloc_tgt0 = 16'h0020; bus.alloc_tgt1 = 16'h0030; bus.alloc_pred = 2'b00;
        #1;
        n_total++; if (bus.alloc_gnt !== 2'b11) $display("FAIL pair_gnt got=%b exp=11", bus.alloc_gnt); else n_pass++;
        n_total++; if (bus.alloc_tag0 !== 1'b0) $display("FAIL pair_tag0 got=%0d exp=0", bus.alloc_tag0); else n_pass++;
        n_total++; if (bus.alloc_tag1 !== 1'b1) $display("FAIL pair_tag1 got=%0d exp=1", bus.alloc_tag1); else n_pass++;
        tick();
        idle_inputs();
        n_total++; if (bus.brnch_cnt !== 2'd2) $display("FAIL pair_cnt got=%0d exp=2", bus.brnch_cnt); else n_pass++;
        n_total++; if (bus.brch_full !== 1'b1) $display("FAIL pair_full got=%b exp=1", bus.brch_full); else n_pass++;
    endtask

    task automatic test_commit_full();
        bus.commit_vld = 1'b1; bus.commit_tag = 1'b0; bus.alloc_req = 2'b01; bus.alloc_pc0 = 16'h0018;
        #1;
        n_total++; if (bus.alloc_gnt !== 2'b00) $display("FAIL full_nobypass_gnt got=%b exp=00", bus.alloc_gnt); else n_pass++;
        tick();
        idle_inputs();
        n_total++; if (bus.brnch_cnt !== 2'd1) $display("FAIL full_commit_cnt got=%0d exp=1", bus.brnch_cnt); else n_pass++;
        n_total++; if (bus.err_tag !== 1'b0) $display("FAIL full_commit_err got=%b exp=0", bus.err_tag); else n_pass++;
        bus.alloc_req = 2'b01; bus.alloc_pc0 = 16'h001C;
        #1;
        n_total++; if (bus.alloc_gnt !== 2'b01) $display("FAIL wrap_gnt got=%b exp=01", bus.alloc_gnt); else n_pass++;
        n_total++; if (bus.alloc_tag0 !== 1'b0) $display("FAIL wrap_tag0 got=%0d exp=0", bus.alloc_tag0); else n_pass++;
        tick();
        idle_inputs();
        n_total++; if (bus.brnch_cnt !== 2'd2) $display("FAIL wrap_cnt got=%0d exp=2", bus.brnch_cnt); else n_pass++;
        bus.commit_vld = 1'b1; bus.commit_tag = 1'b1;
        tick();
        idle_inputs();
        n_total++; if (bus.brnch_cnt !== 2'd1) $display("FAIL retire1_cnt got=%0d exp=1", bus.brnch_cnt); else n_pass++;
    endtask

    task automatic test_partial();
        bus.alloc_req = 2'b11;
        #1;
        n_total++; if (bus.alloc_gnt !== 2'b01) $display("FAIL part_gnt11 got=%b exp=01", bus.alloc_gnt); else n_pass++;
        n_total++; if (bus.alloc_tag0 !== 1'b1) $display("FAIL part_tag0 got=%0d exp=1", bus.alloc_tag0); else n_pass++;
        bus.alloc_req = 2'b10;
        #1;
        n_total++; if (bus.alloc_gnt !== 2'b10) $display("FAIL part_gnt10 got=%b exp=10", bus.alloc_gnt); else n_pass++;
        n_total++; if (bus.alloc_tag1 !== 1'b1) $display("FAIL part_tag1 got=%0d exp=1", bus.alloc_tag1); else n_pass++;
        idle_inputs();
        bus.commit_vld = 1'b1; bus.commit_tag = 1'b0;
        tick();
        idle_inputs();
        n_total++; if (bus.brnch_cnt !== 2'd0) $display("FAIL part_drain_cnt got=%0d exp=0", bus.brnch_cnt); else n_pass++;
    endtask

    task automatic test_mispred_taken();
        int stall_cycles;
        bus.alloc_req = 2'b01; bus.alloc_pc0 = 16'h0040; bus.alloc_tgt0 = 16'h0200; bus.alloc_pred = 2'b01;
        #1;
        n_total++; if (bus.alloc_tag0 !== 1'b1) $display("FAIL mt_tag0 got=%0d exp=1", bus.alloc_tag0); else n_pass++;
        tick();
        idle_inputs();
        bus.commit_vld = 1'b1; bus.commit_tag = 1'b1; bus.commit_mispred = 1'b1; bus.alloc_req = 2'b01;
        exp_q.push_back(16'h0041);
        #1;
        n_total++; if (bus.alloc_gnt !== 2'b00) $display("FAIL mt_flush_gnt got=%b exp=00", bus.alloc_gnt); else n_pass++;
        tick();
        bus.commit_vld = 1'b0; bus.commit_mispred = 1'b0;
        n_total++; if (bus.redirect_vld !== 1'b1) $display("FAIL mt_rvld got=%b exp=1", bus.redirect_vld); else n_pass++;
        n_total++; if (bus.redirect_pc !== 16'h0041) $display("FAIL mt_rpc got=%h exp=0041", bus.redirect_pc); else n_pass++;
        n_total++; if (bus.brnch_cnt !== 2'd0) $display("FAIL mt_cnt got=%0d exp=0", bus.brnch_cnt); else n_pass++;
        n_total++; if (bus.dbg_state !== 1'b1) $display("FAIL mt_state got=%b exp=1", bus.dbg_state); else n_pass++;
        stall_cycles = (bus.stall_fetch === 1'b1) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.stall_fetch !== 1'b1) break;
            stall_cycles++;
            n_total++; if (bus.alloc_gnt !== 2'b00) $display("FAIL mt_stall_gnt got=%b exp=00", bus.alloc_gnt); else n_pass++;
            n_total++; if (bus.redirect_vld !== 1'b0) $display("FAIL mt_rvld_pulse got=%b exp=0", bus.redirect_vld); else n_pass++;
        end
        n_total++; if (stall_cycles != 3) $display("FAIL mt_stall_len got=%0d exp=3", stall_cycles); else n_pass++;
        n_total++; if (bus.alloc_gnt !== 2'b01) $display("FAIL mt_resume_gnt got=%b exp=01", bus.alloc_gnt); else n_pass++;
        n_total++; if (bus.alloc_tag0 !== 1'b0) $display("FAIL mt_resume_tag0 got=%0d exp=0", bus.alloc_tag0); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_mispred_not_taken();
        bus.alloc_req = 2'b01; bus.alloc_pc0 = 16'h0050; bus.alloc_tgt0 = 16'h0100; bus.alloc_pred = 2'b00;
        tick();
        idle_inputs();
        bus.commit_vld = 1'b1; bus.commit_tag = 1'b0; bus.commit_mispred = 1'b1;
        exp_q.push_back(16'h0100);
        tick();
        idle_inputs();
        n_total++; if (bus.redirect_vld !== 1'b1) $display("FAIL mn_rvld got=%b exp=1", bus.redirect_vld); else n_pass++;
        n_total++; if (bus.redirect_pc !== 16'h0100) $display("FAIL mn_rpc got=%h exp=0100", bus.redirect_pc); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            if (bus.stall_fetch !== 1'b1) break;
            tick();
        end
        n_total++; if (bus.stall_fetch !== 1'b0) $display("FAIL mn_stall_timeout got=%b exp=0", bus.stall_fetch); else n_pass++;
    endtask

    task automatic test_err();
        bus.commit_vld = 1'b1; bus.commit_tag = 1'b0;
        tick();
        idle_inputs();
        n_total++; if (bus.err_tag !== 1'b1) $display("FAIL err_empty got=%b exp=1", bus.err_tag); else n_pass++;
        n_total++; if (bus.brnch_cnt !== 2'd0) $display("FAIL err_empty_cnt got=%0d exp=0", bus.brnch_cnt); else n_pass++;
        bus.alloc_req = 2'b01; bus.alloc_pc0 = 16'h0070;
        tick();
        idle_inputs();
        n_total++; if (bus.err_tag !== 1'b0) $display("FAIL err_pulse got=%b exp=0", bus.err_tag); else n_pass++;
        bus.commit_vld = 1'b1; bus.commit_tag = 1'b1;
        tick();
        idle_inputs();
        n_total++; if (bus.err_tag !== 1'b1) $display("FAIL err_badtag got=%b exp=1", bus.err_tag); else n_pass++;
        n_total++; if (bus.brnch_cnt !== 2'd1) $display("FAIL err_badtag_cnt got=%0d exp=1", bus.brnch_cnt); else n_pass++;
        bus.commit_vld = 1'b1; bus.commit_tag = 1'b0;
        tick();
        idle_inputs();
        n_total++; if (bus.err_tag !== 1'b0) $display("FAIL err_legal got=%b exp=0", bus.err_tag); else n_pass++;
        n_total++; if (bus.brnch_cnt !== 2'd0) $display("FAIL err_legal_cnt got=%0d exp=0", bus.brnch_cnt); else n_pass++;
    endtask

    task automatic test_reset_in_recover();
        bus.alloc_req = 2'b01; bus.alloc_pc0 = 16'h0060; bus.alloc_pred = 2'b01;
        tick();
        idle_inputs();
        bus.commit_vld = 1'b1; bus.commit_tag = 1'b1; bus.commit_mispred = 1'b1;
        exp_q.push_back(16'h0061);
        tick();
        idle_inputs();
        n_total++; if (bus.stall_fetch !== 1'b1) $display("FAIL rr_stall got=%b exp=1", bus.stall_fetch); else n_pass++;
        bus.commit_vld = 1'b1; bus.commit_tag = 1'b0;
        tick();
        idle_inputs();
        n_total++; if (bus.err_tag !== 1'b1) $display("FAIL rr_err_recover got=%b exp=1", bus.err_tag); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.stall_fetch !== 1'b0) $display("FAIL rr_async_stall got=%b exp=0", bus.stall_fetch); else n_pass++;
        n_total++; if (bus.brnch_cnt !== 2'd0) $display("FAIL rr_async_cnt got=%0d exp=0", bus.brnch_cnt); else n_pass++;
        n_total++; if (bus.err_tag !== 1'b0) $display("FAIL rr_async_err got=%b exp=0", bus.err_tag); else n_pass++;
        n_total++; if (bus.dbg_state !== 1'b0) $display("FAIL rr_async_state got=%b exp=0", bus.dbg_state); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.alloc_req = 2'b11;
        #1;
        n_total++; if (bus.alloc_gnt !== 2'b11) $display("FAIL rr_post_gnt got=%b exp=11", bus.alloc_gnt); else n_pass++;
        n_total++; if (bus.alloc_tag1 !== 1'b1) $display("FAIL rr_post_tag1 got=%0d exp=1", bus.alloc_tag1); else n_pass++;
        tick();
        idle_inputs();
        n_total++; if (bus.brnch_cnt !== 2'd2) $display("FAIL rr_post_cnt got=%0d exp=2", bus.brnch_cnt); else n_pass++;
    endtask

    task automatic test_random();
        int m_cnt, m_head, m_tail, free_n, n_gnt;
        logic e_g0, e_g1, do_commit;
        logic [1:0] req;
        logic e_t0, e_t1;
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_cnt = 0; m_head = 0; m_tail = 0;
        for (int it = 0; it < 40; it++) begin
            req       = 2'($urandom_range(0, 3));
            do_commit = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
            bus.alloc_req  = req;
            bus.alloc_pc0  = 16'($urandom_range(0, 65535));
            bus.alloc_pc1  = 16'($urandom_range(0, 65535));
            bus.commit_vld = do_commit;
            bus.commit_tag = 1'(m_head);
            free_n = 2 - m_cnt;
            e_g0 = req[0] && (free_n >= 1);
            e_g1 = req[1] && (req[0] ? (e_g0 && free_n >= 2) : (free_n >= 1));
            e_t0 = 1'(m_tail);
            e_t1 = e_g0 ? 1'((m_tail + 1) % 2) : 1'(m_tail);
            #1;
            n_total++; if (bus.alloc_gnt !== {e_g1, e_g0}) $display("FAIL rnd_gnt it=%0d got=%b exp=%b", it, bus.alloc_gnt, {e_g1, e_g0}); else n_pass++;
            if (e_g0) begin
                n_total++; if (bus.alloc_tag0 !== e_t0) $display("FAIL rnd_tag0 it=%0d got=%0d exp=%0d", it, bus.alloc_tag0, e_t0); else n_pass++;
            end
            if (e_g1) begin
                n_total++; if (bus.alloc_tag1 !== e_t1) $display("FAIL rnd_tag1 it=%0d got=%0d exp=%0d", it, bus.alloc_tag1, e_t1); else n_pass++;
            end
            tick();
            idle_inputs();
            n_gnt  = int'(e_g0) + int'(e_g1);
            m_cnt  = m_cnt + n_gnt - (do_commit ? 1 : 0);
            m_tail = (m_tail + n_gnt) % 2;
            if (do_commit) m_head = (m_head + 1) % 2;
            n_total++; if (bus.brnch_cnt !== 2'(m_cnt)) $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", it, bus.brnch_cnt, m_cnt); else n_pass++;
            n_total++; if (bus.err_tag !== 1'b0) $display("FAIL rnd_err it=%0d got=%b exp=0", it, bus.err_tag); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_alloc_pair();
        test_commit_full();
        test_partial();
        test_mispred_taken();
        test_mispred_not_taken();
        test_err();
        test_reset_in_recover();
        test_random();
        tick();
        n_total++; if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
